conv3x3_engine: RTL and testbench

CONV3X3_ENGINE -- requirements
Module: conv3x3_engine

---
 rtl/vision_pkg.sv | 26 ++
 rtl/vision_round_sat.sv | 40 ++++
 rtl/conv3x3_engine.sv | 174 +++++++++++++++++
 tb/tb_conv3x3_engine.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vision_pkg.sv
// Shared vision-pipeline types, constants and width helpers.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package vision_pkg;

    localparam int KERNEL_SIZE    = 3;
    localparam int KERNEL_TAPS    = KERNEL_SIZE * KERNEL_SIZE;
    localparam int COEF_WIDTH_DEF = 8;

    // Flat kernel storage, index = row*KERNEL_SIZE + col.
    typedef logic signed [COEF_WIDTH_DEF-1:0] coef_arr_t [KERNEL_TAPS];

    // Pass-through kernel: only the centre tap is 1.
    localparam coef_arr_t KERNEL_IDENTITY = '{
        8'sd0, 8'sd0, 8'sd0,
        8'sd0, 8'sd1, 8'sd0,
        8'sd0, 8'sd0, 8'sd0
    };

    // Product width (pixel zero-extended to signed times coef) plus 4 guard
    // bits, enough headroom for the sum of 9 taps.
    function automatic int acc_width(input int data_w, input int coef_w);
        return data_w + coef_w + 1 + 4;
    endfunction

endpackage

// File: rtl/vision_round_sat.sv
// Signed accumulator -> unsigned pixel: optional round, arithmetic shift, abs/clamp-to-zero, saturate.
// Latency: 0 (purely combinational).
// Backpressure: none; output follows input.
module vision_round_sat #(
    parameter int ACC_W       = 21,
    parameter int OUT_W       = 8,
    parameter bit PRE_ROUNDED = 1'b0
) (
    input  logic signed [ACC_W-1:0] acc,
    input  logic        [3:0]       shift,
    input  logic                    abs_en,
    output logic        [OUT_W-1:0] result
);

    localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'((1 << OUT_W) - 1);

    logic signed [ACC_W-1:0] rounded;
    logic signed [ACC_W-1:0] shifted;
    logic signed [ACC_W-1:0] mag;

    // Round half-up (unless the caller already folded the term in), shift, rectify, clamp.
    always_comb begin
        rounded = acc;
        if (!PRE_ROUNDED && shift != 4'd0) begin
            rounded = acc + (ACC_W'(1) << (shift - 4'd1));
        end
        shifted = rounded >>> shift;
        if (shifted < 0) begin
            mag = abs_en ? -shifted : '0;
        end else begin
            mag = shifted;
        end
        if (mag > SAT_MAX) begin
            result = '1;
        end else begin
            result = mag[OUT_W-1:0];
        end
    end

endmodule

// File: rtl/conv3x3_engine.sv
// 3x3 signed-kernel convolution with double-buffered coefficients and frame/row position flags.
// Latency: 4 cycles from window_valid to out_valid.
// Backpressure: none; the pipeline never stalls, frame_start/rst flush in-flight results.
module conv3x3_engine
    import vision_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int COEF_WIDTH = 8,
    parameter int LATENCY    = 4
) (
    input  logic                                                   clk,
    input  logic                                                   rst,
    input  logic                                                   window_valid,
    input  logic [KERNEL_SIZE-1:0][KERNEL_SIZE-1:0][DATA_WIDTH-1:0] window_data,
    input  logic                                                   frame_start,
    input  logic [15:0]                                            img_width,
    input  logic                                                   coef_we,
    input  logic [3:0]                                             coef_addr,
    input  logic signed [COEF_WIDTH-1:0]                           coef_data,
    input  logic [3:0]                                             shift_cfg,
    input  logic                                                   abs_en,
    output logic                                                   out_valid,
    output logic [DATA_WIDTH-1:0]                                  out_data,
    output logic                                                   out_sof,
    output logic                                                   out_eol
);

    localparam int PROD_W = DATA_WIDTH + COEF_WIDTH + 1;
    localparam int ACC_W  = acc_width(DATA_WIDTH, COEF_WIDTH);

    if (LATENCY != 4) begin : g_bad_latency
        $error("conv3x3_engine: pipeline depth is fixed at 4");
    end

    logic signed [COEF_WIDTH-1:0] shd_coef [KERNEL_TAPS];
    logic signed [COEF_WIDTH-1:0] act_coef [KERNEL_TAPS];
    logic [3:0]                   shd_shift, act_shift;
    logic                         shd_abs, act_abs;

    logic                         v1, v2, v3;
    logic signed [PROD_W-1:0]     prod [KERNEL_TAPS];
    logic signed [ACC_W-1:0]      rsum [KERNEL_SIZE];
    logic signed [ACC_W-1:0]      total;
    logic signed [ACC_W-1:0]      rnd;
    logic [DATA_WIDTH-1:0]        sat_val;

    logic [15:0]                  col;
    logic [15:0]                  wlim;
    logic                         sof_done;

    // Shadow bank takes writes any time; active bank swaps in on frame_start (pre-write shadow value).
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < KERNEL_TAPS; i++) begin
                shd_coef[i] <= COEF_WIDTH'(KERNEL_IDENTITY[i]);
                act_coef[i] <= COEF_WIDTH'(KERNEL_IDENTITY[i]);
            end
            shd_shift <= '0;
            act_shift <= '0;
            shd_abs   <= 1'b0;
            act_abs   <= 1'b0;
        end else begin
            shd_shift <= shift_cfg;
            shd_abs   <= abs_en;
            if (coef_we && coef_addr < 4'(KERNEL_TAPS)) begin
                shd_coef[coef_addr] <= coef_data;
            end
            if (frame_start) begin
                act_coef  <= shd_coef;
                act_shift <= shd_shift;
                act_abs   <= shd_abs;
            end
        end
    end

    // Stage valid chain; a new frame or reset discards everything in flight.
    always_ff @(posedge clk) begin
        if (rst || frame_start) begin
            v1        <= 1'b0;
            v2        <= 1'b0;
            v3        <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            v1        <= window_valid;
            v2        <= v1;
            v3        <= v2;
            out_valid <= v3;
        end
    end

    // Stage 1: nine pixel*coef products; pixels are unsigned so prepend a zero sign bit.
    always_ff @(posedge clk) begin
        if (window_valid && !frame_start) begin
            for (int r = 0; r < KERNEL_SIZE; r++) begin
                for (int c = 0; c < KERNEL_SIZE; c++) begin
                    prod[r*KERNEL_SIZE+c] <= PROD_W'($signed({1'b0, window_data[r][c]}))
                                           * PROD_W'(act_coef[r*KERNEL_SIZE+c]);
                end
            end
        end
    end

    // Stage 2: per-row sums.
    always_ff @(posedge clk) begin
        if (v1) begin
            for (int r = 0; r < KERNEL_SIZE; r++) begin
                rsum[r] <= ACC_W'(prod[r*KERNEL_SIZE])
                         + ACC_W'(prod[r*KERNEL_SIZE+1])
                         + ACC_W'(prod[r*KERNEL_SIZE+2]);
            end
        end
    end

    // Half-LSB rounding term for the coming right shift; nothing to round when shift is 0.
    always_comb begin
        rnd = '0;
        if (act_shift != 4'd0) begin
            rnd = ACC_W'(1) << (act_shift - 4'd1);
        end
    end

    // Stage 3: kernel total with the rounding term folded in.
    always_ff @(posedge clk) begin
        if (v2) begin
            total <= rsum[0] + rsum[1] + rsum[2] + rnd;
        end
    end

    vision_round_sat #(
        .ACC_W       (ACC_W),
        .OUT_W       (DATA_WIDTH),
        .PRE_ROUNDED (1'b1)
    ) u_round_sat (
        .acc    (total),
        .shift  (act_shift),
        .abs_en (act_abs),
        .result (sat_val)
    );

    // Stage 4: register the saturated pixel; hold it between valid results.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_data <= '0;
        end else if (v3) begin
            out_data <= sat_val;
        end
    end

    // Column counter and first-of-frame tracking; width 0 behaves as width 1.
    always_ff @(posedge clk) begin
        if (rst) begin
            col      <= '0;
            wlim     <= '0;
            sof_done <= 1'b0;
            out_sof  <= 1'b0;
            out_eol  <= 1'b0;
        end else if (frame_start) begin
            col      <= '0;
            wlim     <= (img_width == 16'd0) ? 16'd0 : img_width - 16'd1;
            sof_done <= 1'b0;
            out_sof  <= 1'b0;
            out_eol  <= 1'b0;
        end else if (v3) begin
            out_sof  <= ~sof_done;
            sof_done <= 1'b1;
            out_eol  <= (col == wlim);
            col      <= (col == wlim) ? 16'd0 : col + 16'd1;
        end else begin
            out_sof  <= 1'b0;
            out_eol  <= 1'b0;
        end
    end

endmodule

// File: tb/tb_conv3x3_engine.sv
// Scoreboard bench for conv3x3_engine: directed windows with hand-computed pixels.
// Latency: checks each result lands exactly 4 cycles after its window.
// Backpressure: none; monitor pops whenever out_valid is seen.
module tb_conv3x3_engine;

    localparam int DW = 8;
    localparam int CW = 8;

    logic                      clk = 1'b0;
    logic                      rst;
    logic                      window_valid;
    logic [2:0][2:0][DW-1:0]   window_data;
    logic                      frame_start;
    logic [15:0]               img_width;
    logic                      coef_we;
    logic [3:0]                coef_addr;
    logic signed [CW-1:0]      coef_data;
    logic [3:0]                shift_cfg;
    logic                      abs_en;
    logic                      out_valid;
    logic [DW-1:0]             out_data;
    logic                      out_sof;
    logic                      out_eol;

    always #5 clk = ~clk;

    conv3x3_engine #(
        .DATA_WIDTH (DW),
        .COEF_WIDTH (CW),
        .LATENCY    (4)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .window_valid (window_valid),
        .window_data  (window_data),
        .frame_start  (frame_start),
        .img_width    (img_width),
        .coef_we      (coef_we),
        .coef_addr    (coef_addr),
        .coef_data    (coef_data),
        .shift_cfg    (shift_cfg),
        .abs_en       (abs_en),
        .out_valid    (out_valid),
        .out_data     (out_data),
        .out_sof      (out_sof),
        .out_eol      (out_eol)
    );

    typedef struct {
        logic [7:0] data;
        bit         sof;
        bit         eol;
        bit         eol_chk;
        int         cyc;
        string      name;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;
    bit   m_first;
    int   m_col;
    int   m_wlim;

    int ident_k[9] = '{0, 0, 0, 0, 1, 0, 0, 0, 0};
    int box_k[9]   = '{1, 1, 1, 1, 1, 1, 1, 1, 1};
    int sobel_k[9] = '{-1, 0, 1, -2, 0, 2, -1, 0, 1};

    always @(posedge clk) cyc++;

    function automatic void chk(input string name, input int act, input int expv);
        n_checks++;
        if (act != expv) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, expv);
        end
    endfunction

    function automatic logic [2:0][2:0][7:0] cols(input logic [7:0] c0, input logic [7:0] c1,
                                                  input logic [7:0] c2);
        logic [2:0][2:0][7:0] w;
        for (int r = 0; r < 3; r++) begin
            w[r][0] = c0;
            w[r][1] = c1;
            w[r][2] = c2;
        end
        return w;
    endfunction

    function automatic logic [2:0][2:0][7:0] seq9();
        logic [2:0][2:0][7:0] w;
        for (int r = 0; r < 3; r++)
            for (int c = 0; c < 3; c++)
                w[r][c] = 8'(r*3 + c + 1);
        return w;
    endfunction

    // Monitor: every out_valid must match the head of the scoreboard.
    exp_t m_e;
    always @(negedge clk) begin
        if (!rst && out_valid) begin
            if (sb.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_output: got out_valid=1 data=%0d, expected no output", out_data);
            end else begin
                m_e = sb.pop_front();
                chk({m_e.name, "_data"}, int'(out_data), int'(m_e.data));
                chk({m_e.name, "_cycle"}, cyc, m_e.cyc);
                chk({m_e.name, "_sof"}, int'(out_sof), int'(m_e.sof));
                if (m_e.eol_chk) chk({m_e.name, "_eol"}, int'(out_eol), int'(m_e.eol));
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic win(input logic [2:0][2:0][7:0] w, input logic [7:0] expd,
                       input string name, input bit eol_chk = 1'b1);
        exp_t e;
        window_data  = w;
        window_valid = 1'b1;
        e.data    = expd;
        e.name    = name;
        e.cyc     = cyc + 4;
        e.eol_chk = eol_chk;
        e.sof     = m_first;
        m_first   = 1'b0;
        e.eol     = (m_col == m_wlim);
        m_col     = e.eol ? 0 : m_col + 1;
        sb.push_back(e);
        step();
        window_valid = 1'b0;
    endtask

    task automatic win_drop(input logic [2:0][2:0][7:0] w);
        window_data  = w;
        window_valid = 1'b1;
        step();
        window_valid = 1'b0;
    endtask

    task automatic fs(input int w);
        frame_start = 1'b1;
        img_width   = 16'(w);
        m_first     = 1'b1;
        m_col       = 0;
        m_wlim      = (w == 0) ? 0 : w - 1;
        step();
        frame_start = 1'b0;
    endtask

    task automatic set_kernel(input int k[9], input int sh, input bit ab);
        shift_cfg = 4'(sh);
        abs_en    = ab;
        for (int i = 0; i < 9; i++) begin
            coef_we   = 1'b1;
            coef_addr = 4'(i);
            coef_data = CW'(k[i]);
            step();
        end
        coef_we = 1'b0;
    endtask

    initial begin
        rst = 1'b1; window_valid = 1'b0; window_data = '0; frame_start = 1'b0;
        img_width = '0; coef_we = 1'b0; coef_addr = '0; coef_data = '0;
        shift_cfg = '0; abs_en = 1'b0;
        m_first = 1'b1; m_col = 0; m_wlim = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_out_valid", int'(out_valid), 0);
        chk("reset_out_data", int'(out_data), 0);
        chk("reset_out_sof", int'(out_sof), 0);
        chk("reset_out_eol", int'(out_eol), 0);
        step();
        rst = 1'b0;
        step();

        // Identity kernel from reset: only the centre pixel passes.
        fs(1);
        win(cols(8'h11, 8'h5A, 8'h22), 8'h5A, "identity");
        win(cols(8'hFF, 8'h00, 8'hFF), 8'h00, "identity_zero");
        repeat (5) step();

        // Box kernel, shift 3: 2295+4>>3=287 saturates; 144+4>>3=18; 45+4>>3=6.
        set_kernel(box_k, 3, 1'b0);
        fs(3);
        win(cols(8'hFF, 8'hFF, 8'hFF), 8'hFF, "box_sat");
        win(cols(8'h10, 8'h10, 8'h10), 8'h12, "box_16");
        win(seq9(), 8'd6, "box_seq");
        repeat (5) step();

        // Sobel-X with magnitude: -1020 -> 255, -64 -> 64.
        set_kernel(sobel_k, 0, 1'b1);
        fs(2);
        win(cols(8'hFF, 8'h33, 8'h00), 8'hFF, "sobel_abs");
        win(cols(8'h10, 8'h77, 8'h00), 8'h40, "sobel_abs_small");
        repeat (5) step();

        // Sobel-X clamping negatives: -1020 -> 0, +64 -> 64.
        set_kernel(sobel_k, 0, 1'b0);
        fs(2);
        win(cols(8'hFF, 8'h33, 8'h00), 8'h00, "sobel_clamp");
        win(cols(8'h00, 8'h55, 8'h10), 8'h40, "sobel_pos");
        repeat (5) step();

        // Rounding with shift 3: (+20+4)>>>3 = 3, (-20+4)>>>3 = -2 -> magnitude 2.
        set_kernel(sobel_k, 3, 1'b1);
        fs(2);
        win(cols(8'h00, 8'h00, 8'h05), 8'd3, "round_pos");
        win(cols(8'h05, 8'h00, 8'h00), 8'd2, "round_neg");
        repeat (5) step();

        // Row framing: width 4, 8 outputs -> sof on 1, eol on 4 and 8.
        set_kernel(ident_k, 0, 1'b0);
        fs(4);
        for (int i = 1; i <= 8; i++) win(cols(8'h00, 8'(i), 8'h00), 8'(i), "width4");
        repeat (5) step();

        // Width 0 acts as width 1: eol on every output.
        fs(0);
        for (int i = 1; i <= 3; i++) win(cols(8'h00, 8'(i + 16), 8'h00), 8'(i + 16), "width0");
        repeat (5) step();

        // Mid-frame shadow write must not disturb the active identity kernel.
        fs(2);
        win(cols(8'h00, 8'h40, 8'h00), 8'h40, "pre_write");
        set_kernel(box_k, 3, 1'b0);
        win(cols(8'h00, 8'h40, 8'h00), 8'h40, "old_kernel_kept");
        repeat (5) step();
        fs(2);
        win(cols(8'h00, 8'h40, 8'h00), 8'h18, "new_kernel");
        repeat (5) step();

        // Shadow write coinciding with frame_start: active takes the pre-write box kernel.
        coef_we = 1'b1; coef_addr = 4'd4; coef_data = 8'sd5;
        fs(1);
        coef_we = 1'b0;
        win(cols(8'h08, 8'h08, 8'h08), 8'd9, "coincide_old");
        repeat (5) step();
        fs(1);
        win(cols(8'h08, 8'h08, 8'h08), 8'd13, "coincide_new");
        repeat (5) step();

        // frame_start with three windows in flight (plus one coincident window) discards all four.
        set_kernel(ident_k, 0, 1'b0);
        fs(5);
        win_drop(cols(8'h00, 8'hA1, 8'h00));
        win_drop(cols(8'h00, 8'hA2, 8'h00));
        win_drop(cols(8'h00, 8'hA3, 8'h00));
        window_valid = 1'b1;
        window_data  = cols(8'h00, 8'hA4, 8'h00);
        fs(5);
        window_valid = 1'b0;
        repeat (6) step();
        win(cols(8'h00, 8'h21, 8'h00), 8'h21, "after_fs");
        repeat (5) step();

        // rst with three windows in flight: discarded, coefficients back to identity, sof re-armed.
        set_kernel(box_k, 3, 1'b0);
        fs(5);
        win_drop(cols(8'h00, 8'hB1, 8'h00));
        win_drop(cols(8'h00, 8'hB2, 8'h00));
        win_drop(cols(8'h00, 8'hB3, 8'h00));
        rst = 1'b1;
        step();
        rst = 1'b0;
        m_first = 1'b1;
        m_col   = 0;
        @(negedge clk);
        chk("rst_flush_valid", int'(out_valid), 0);
        step();
        repeat (5) step();
        win(cols(8'h00, 8'h21, 8'h00), 8'h21, "after_rst", 1'b0);

        for (int i = 0; i < 20 && sb.size() > 0; i++) @(negedge clk);
        chk("scoreboard_drained", sb.size(), 0);
        repeat (2) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
